fadd_arbiter: RTL
=================

Name: fadd_arbiter

Overview:
- Shares one fixed-latency, non-stalling pipelined fadd unit between NREQ requesters.
- Round-robin arbitration; at most one add is issued per cycle.
- Tracks each in-flight operation's owner in a tag pipeline that mirrors the fadd latency, then routes each result back to its owner.
- Sits between the core's FP issue ports and the fadd instance; connects to fadd through its op1/op2/result ports.

Parameters:
- NREQ, 4, number of requesters (2..8).
- FADD_LAT, 3, cycles from fadd_op1/fadd_op2 being stable at a clk edge to fadd_result valid.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant.
  - Handshake completes when req_valid[i] and req_ready[i] are both high.
- req_op1  in  NREQ*32  operand 1; requester i uses bits [32i+31:32i].
- req_op2  in  NREQ*32  operand 2; same packing as req_op1.
- resp_valid  out  NREQ  one-cycle pulse marking the owner's result.
- resp_result  out  32  result, broadcast to all requesters; qualified by resp_valid.
- fadd_op1  out  32  registered operand 1 to fadd.
- fadd_op2  out  32  registered operand 2 to fadd.
- fadd_result  in  32  fadd output.
- busy  out  1  high if any operation is in flight.

Behaviour:
- Reset (synchronous, active-high), values in the cycle after reset is sampled high:
  - rr_ptr = 0.
  - Tag pipeline: all valid bits 0.
  - fadd_op1 = fadd_op2 = 0.
  - resp_valid = 0; busy = 0.
  - req_ready = 0 while reset is high.
- Arbitration (combinational, every cycle):
  - Grant goes to the first i with req_valid[i] = 1, scanning upward from rr_ptr with wrap-around modulo NREQ.
  - req_ready is one-hot to the winner, or all zero if there are no requests.
  - req_ready does not depend on the fadd state, because fadd never stalls.
  - req_ready[i] may be high only when req_valid[i] is high.
- Pointer update:
  - On a grant to i, rr_ptr <= (i+1) mod NREQ.
  - With no grant, rr_ptr holds.
- Issue stage:
  - On a grant, fadd_op1/fadd_op2 <= the winner's operands.
  - With no grant, fadd_op1/fadd_op2 <= 0 (the bubble is a harmless 0+0).
- Tag pipeline:
  - FADD_LAT+1 stages of {valid, idx[$clog2(NREQ)-1:0]}, shifting every cycle.
  - Stage 0 is loaded with {grant, winner} in the same edge as fadd_op.
- Response timing:
  - Handshake at edge t → fadd_op stable after t → fadd_result valid after edge t+FADD_LAT.
  - The last tag stage is aligned so that resp_valid[idx] = 1 in the cycle following edge t+FADD_LAT, i.e. total latency is FADD_LAT+1 edges.
- Response outputs:
  - resp_result = fadd_result, passed through combinationally.
  - resp_valid is decoded combinationally from the last tag stage.
- Throughput:
  - One issue per cycle sustained.
  - Results return in issue order and are never dropped.
  - Requesters must accept resp_valid unconditionally; there is no response backpressure.
- busy = OR of all tag valid bits.
- Boundary conditions:
  - All NREQ requesting continuously → grants cycle 0,1,2,3,0,... (strict rotation).
  - A single requester holding valid → granted every cycle.
  - Requester i withdraws valid before its grant → it is skipped; no penalty to others.
  - Reset mid-operation → all in-flight tags are discarded; no resp_valid appears for them after reset, even though fadd still emits results.
  - Simultaneous response to i and new grant to i in the same cycle → both are legal and independent.

Decomposition:
- Package fadd_arb_pkg:
  - FP32_W = 32.
  - Typedef fp32_t.
  - Typedef tag_t struct {valid, idx}.
  - Function rr_pick(valid, ptr) returning a one-hot vector.
- Sub-module rr_arbiter (NREQ): inputs req and ptr_update, outputs one-hot grant plus internal ptr. Reusable for fmul/fdiv sharing later.
- The tag shift register stays inline.

Test Plan:
- Reset then idle, no req_valid for 10 cycles → req_ready = 0, resp_valid = 0, busy = 0, fadd_op1/fadd_op2 = 0.
- Req 2 alone, op1=0x3F800000 (1.0), op2=0x40000000 (2.0), with the real fadd instance attached → req_ready[2] same cycle; resp_valid = 4'b0100 exactly FADD_LAT+1 (4) edges later; resp_result = 0x40400000 (3.0); busy high for exactly those cycles.
- All 4 requesting continuously for 8 cycles, requester i op1 = i+1.0 and op2 = 1.0 → grant order 0,1,2,3,0,1,2,3; responses in the same order, each 4 cycles after its grant; results 2.0, 3.0, 4.0, 5.0 repeating.
- rr_ptr = 3 with requests only from 1 and 3 → grant 3, then 1, then 3; no grant goes to a non-requesting port.
- Issue 3 ops back-to-back, assert reset for 1 cycle at the edge after the third grant → no resp_valid for any of those ops; busy = 0 after reset; a new request after reset returns correctly.
- Random soak, 1000 ops with random valids and random operands, scoreboard keyed by requester → every handshake gets exactly one resp_valid; resp_result is bit-exact to the fadd reference model; order is preserved per requester.

Source files
------------

// File: rtl/fadd_arb_pkg.sv
// Shared types and the round-robin pick function for
// arbitrating a single pipelined FP unit between requesters.
package fadd_arb_pkg;

    localparam int FP32_W  = 32;
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef logic [FP32_W-1:0] fp32_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

    // First set bit of valid at or above ptr, wrapping modulo n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [IDX_W-1:0]   ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] pick;
        logic               found;
        logic [IDX_W-1:0]   k;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            k = IDX_W'((int'(ptr) + i) % n);
            if (i < n && !found && valid[k]) begin
                pick[k] = 1'b1;
                found   = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fadd_arbiter_rr.sv
// Round-robin arbiter with a registered rotation pointer.
// Written generically so other shared FP units can reuse it.
module rr_arbiter
    import fadd_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic             ptr_update,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic [IDX_W-1:0] ptr
);

    logic [MAX_REQ-1:0] pick;

    assign pick  = rr_pick(MAX_REQ'(req), ptr, NREQ);
    assign grant = pick[NREQ-1:0];

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant[i])
                grant_idx = IDX_W'(i);
    end

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= '0;
        else if (ptr_update && |grant)
            ptr <= (grant_idx == IDX_W'(NREQ - 1)) ? '0
                                                   : grant_idx + 1'b1;
    end

endmodule

// File: rtl/fadd_arbiter.sv
// Shares one fixed-latency fadd between NREQ requesters and
// routes each result back to its owner via a tag pipeline.
module fadd_arbiter
    import fadd_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int FADD_LAT = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*FP32_W-1:0]   req_op1,
    input  logic [NREQ*FP32_W-1:0]   req_op2,
    output logic [NREQ-1:0]          resp_valid,
    output logic [FP32_W-1:0]        resp_result,
    output logic [FP32_W-1:0]        fadd_op1,
    output logic [FP32_W-1:0]        fadd_op2,
    input  logic [FP32_W-1:0]        fadd_result,
    output logic                     busy
);

    logic [NREQ-1:0]  req_masked;
    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] rr_ptr;
    fp32_t            sel_op1;
    fp32_t            sel_op2;
    tag_t             tag_q [FADD_LAT+1];

    assign req_masked = reset ? '0 : req_valid;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (req_masked),
        .ptr_update(1'b1),
        .grant     (grant),
        .grant_idx (grant_idx),
        .ptr       (rr_ptr)
    );

    assign req_ready = grant;

    always_comb begin
        sel_op1 = '0;
        sel_op2 = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant[i]) begin
                sel_op1 = req_op1[i*FP32_W +: FP32_W];
                sel_op2 = req_op2[i*FP32_W +: FP32_W];
            end
    end

    // Idle cycles issue 0+0 so the unit never sees stale operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            fadd_op1 <= '0;
            fadd_op2 <= '0;
        end else begin
            fadd_op1 <= sel_op1;
            fadd_op2 <= sel_op2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= FADD_LAT; i++)
                tag_q[i] <= '0;
        end else begin
            tag_q[0] <= '{valid: |grant, idx: grant_idx};
            for (int i = 1; i <= FADD_LAT; i++)
                tag_q[i] <= tag_q[i-1];
        end
    end

    assign resp_result = fadd_result;

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NREQ; i++)
            resp_valid[i] = tag_q[FADD_LAT].valid &&
                            (tag_q[FADD_LAT].idx == IDX_W'(i));
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i <= FADD_LAT; i++)
            busy = busy | tag_q[i].valid;
    end

endmodule
